// File: rtl/calc1_port_driver.sv
// Purpose : sequences one calc1 request port (cmd cycle, data cycle, wait) and returns the response.
// Latency : registered bus; cmd on bus 1 cycle after accept, result valid the edge the response is seen.
// Backpr. : one transaction in flight; txn_ready only in IDLE, rsp_* held until rsp_ready.
//
// Ports:
//   c_clk, reset_n                  clock, async active-low reset
//   txn_valid/txn_ready, txn_cmd/op1/op2      upstream transaction handshake
//   req_cmd_out, req_data_out       registered calc1 request bus
//   out_resp, out_data              calc1 port response
//   rsp_valid/rsp_ready, rsp_resp/data/latency/timeout   result handshake
//   spur_cnt                        saturating count of responses seen outside WAIT
//
// Optional: define CALC1_DRV_TIMEOUT_EN to give up after TIMEOUT cycles in WAIT
// (result returned with rsp_resp=0, rsp_data=0, rsp_timeout=1).
module calc1_port_driver #(
    parameter int LAT_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int SPUR_W  = 8
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic              txn_valid,
    output logic              txn_ready,
    input  logic [3:0]        txn_cmd,
    input  logic [31:0]       txn_op1,
    input  logic [31:0]       txn_op2,
    output logic [3:0]        req_cmd_out,
    output logic [31:0]       req_data_out,
    input  logic [1:0]        out_resp,
    input  logic [31:0]       out_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_resp,
    output logic [31:0]       rsp_data,
    output logic [LAT_W-1:0]  rsp_latency,
    output logic              rsp_timeout,
    output logic [SPUR_W-1:0] spur_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DATA = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       op2_q;
    logic [LAT_W-1:0]  lat_cnt;
    logic              resp_hit;
    logic              tmo_hit;

    assign resp_hit  = (out_resp != 2'd0);
    assign txn_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

`ifdef CALC1_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle expires at its closing edge. A response on that
    // same edge takes priority.
    assign tmo_hit = (state == WAIT) && !resp_hit && (wait_cnt == TMO_W'(TIMEOUT - 1));
`else
    // No timeout in this build; the WAIT state is unbounded.
    assign tmo_hit     = (TIMEOUT < 0);
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (txn_valid) state_nxt = CMD;
            CMD:     state_nxt = DATA;
            DATA:    state_nxt = WAIT;
            WAIT:    if (resp_hit || tmo_hit) state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            req_cmd_out  <= '0;
            req_data_out <= '0;
            op2_q        <= '0;
            lat_cnt      <= '0;
            rsp_resp     <= '0;
            rsp_data     <= '0;
            rsp_latency  <= '0;
            spur_cnt     <= '0;
`ifdef CALC1_DRV_TIMEOUT_EN
            wait_cnt     <= '0;
            rsp_timeout  <= 1'b0;
`endif
        end else begin
            // A response outside WAIT belongs to no request of ours.
            if (resp_hit && (state != WAIT) && (spur_cnt != '1)) begin
                spur_cnt <= spur_cnt + SPUR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (txn_valid) begin
                        req_cmd_out  <= txn_cmd;
                        req_data_out <= txn_op1;
                        op2_q        <= txn_op2;
                        lat_cnt      <= '0;
                    end
                end
                CMD: begin
                    req_cmd_out  <= '0;
                    req_data_out <= op2_q;
                    lat_cnt      <= LAT_W'(1);
                end
                DATA: begin
                    req_data_out <= '0;
                    lat_cnt      <= lat_cnt + LAT_W'(1);
`ifdef CALC1_DRV_TIMEOUT_EN
                    wait_cnt     <= '0;
`endif
                end
                WAIT: begin
                    if (lat_cnt != '1) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
`ifdef CALC1_DRV_TIMEOUT_EN
                    wait_cnt <= wait_cnt + TMO_W'(1);
`endif
                    // lat_cnt equals cycles elapsed since the command cycle.
                    if (resp_hit) begin
                        rsp_resp    <= out_resp;
                        rsp_data    <= out_data;
                        rsp_latency <= lat_cnt;
`ifdef CALC1_DRV_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_resp    <= '0;
                        rsp_data    <= '0;
                        rsp_latency <= lat_cnt;
                        rsp_timeout <= 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
module tb_calc1_port_driver;

    logic        c_clk = 1'b0;
    logic        reset_n;
    logic        txn_valid;
    logic        txn_ready;
    logic [3:0]  txn_cmd;
    logic [31:0] txn_op1;
    logic [31:0] txn_op2;
    logic [3:0]  req_cmd_out;
    logic [31:0] req_data_out;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_latency;
    logic        rsp_timeout;
    logic [7:0]  spur_cnt;

    always #5 c_clk = ~c_clk;

    calc1_port_driver #(.LAT_W(8), .TIMEOUT(16), .SPUR_W(8)) dut (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .txn_valid   (txn_valid),
        .txn_ready   (txn_ready),
        .txn_cmd     (txn_cmd),
        .txn_op1     (txn_op1),
        .txn_op2     (txn_op2),
        .req_cmd_out (req_cmd_out),
        .req_data_out(req_data_out),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_resp    (rsp_resp),
        .rsp_data    (rsp_data),
        .rsp_latency (rsp_latency),
        .rsp_timeout (rsp_timeout),
        .spur_cnt    (spur_cnt)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [7:0]  lat;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference calc1 behaviour used by the port stub.
    function automatic exp_t calc_model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input int lat);
        exp_t        e;
        logic [32:0] sum;
        e.lat = 8'(lat);
        e.tmo = 1'b0;
        e.resp = 2'd1;
        e.data = '0;
        case (cmd)
            4'd1: begin
                sum = {1'b0, a} + {1'b0, b};
                if (sum[32]) e.resp = 2'd2;
                else         e.data = sum[31:0];
            end
            4'd2: begin
                if (b > a) e.resp = 2'd2;
                else       e.data = a - b;
            end
            4'd5:    e.data = a << b[4:0];
            4'd6:    e.data = a >> b[4:0];
            default: e.resp = 2'd2;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // Hands a transaction over and checks the request bus; returns in WAIT cycle 0.
    task automatic start_txn(input logic [3:0] cmd, input logic [31:0] a,
                             input logic [31:0] b, input string tag);
        int n = 0;
        while (txn_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (txn_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s txn_ready wait: got %b want 1", tag, txn_ready);
        end
        txn_valid = 1'b1;
        txn_cmd   = cmd;
        txn_op1   = a;
        txn_op2   = b;
        tick();
        txn_valid = 1'b0;
        txn_cmd   = '0;
        txn_op1   = '0;
        txn_op2   = '0;
        checks++;
        if (req_cmd_out !== cmd || req_data_out !== a || txn_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s cmd_cycle: got cmd=%0h data=%0h rdy=%b want cmd=%0h data=%0h rdy=0",
                     tag, req_cmd_out, req_data_out, txn_ready, cmd, a);
        end
        tick();
        checks++;
        if (req_cmd_out !== 4'd0 || req_data_out !== b) begin
            errors++;
            $display("FAIL %s data_cycle: got cmd=%0h data=%0h want cmd=0 data=%0h",
                     tag, req_cmd_out, req_data_out, b);
        end
        tick();
        checks++;
        if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_bus: got cmd=%0h data=%0h vld=%b want 0 0 0",
                     tag, req_cmd_out, req_data_out, rsp_valid);
        end
    endtask

    // Pops the scoreboard against the presented result, optionally stalling first.
    task automatic drain_rsp(input int hold, input string tag);
        exp_t        e;
        logic [1:0]  r0;
        logic [31:0] d0;
        logic [7:0]  l0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rsp_valid: got %b want 1", tag, rsp_valid);
        end
        r0 = rsp_resp;
        d0 = rsp_data;
        l0 = rsp_latency;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || txn_ready !== 1'b0 || rsp_resp !== r0 ||
                rsp_data !== d0 || rsp_latency !== l0) begin
                errors++;
                $display("FAIL %s hold%0d: got vld=%b rdy=%b resp=%0d data=%0h lat=%0d want 1 0 %0d %0h %0d",
                         tag, i, rsp_valid, txn_ready, rsp_resp, rsp_data, rsp_latency, r0, d0, l0);
            end
        end
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue want entry", tag);
        end else begin
            e = sb_q.pop_front();
            if (rsp_resp !== e.resp || rsp_data !== e.data || rsp_latency !== e.lat ||
                rsp_timeout !== e.tmo) begin
                errors++;
                $display("FAIL %s result: got resp=%0d data=%0h lat=%0d tmo=%b want resp=%0d data=%0h lat=%0d tmo=%b",
                         tag, rsp_resp, rsp_data, rsp_latency, rsp_timeout, e.resp, e.data, e.lat, e.tmo);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || txn_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got vld=%b rdy=%b want 0 1", tag, rsp_valid, txn_ready);
        end
    endtask

    // Full transaction; stub answers in WAIT cycle 'delay' (latency 2+delay).
    task automatic run_txn(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                           input int delay, input int hold, input string tag);
        exp_t e;
        start_txn(cmd, a, b, tag);
        e = calc_model(cmd, a, b, 2 + delay);
        sb_q.push_back(e);
        repeat (delay) tick();
        out_resp = e.resp;
        out_data = e.data;
        tick();
        out_resp = '0;
        out_data = '0;
        drain_rsp(hold, tag);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (txn_ready !== 1'b1 || rsp_valid !== 1'b0 || req_cmd_out !== 4'd0 ||
            req_data_out !== 32'd0 || rsp_resp !== 2'd0 || rsp_data !== 32'd0 ||
            rsp_latency !== 8'd0 || rsp_timeout !== 1'b0 || spur_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b cmd=%0h data=%0h resp=%0d rdata=%0h lat=%0d tmo=%b spur=%0d want rdy=1 rest 0",
                     txn_ready, rsp_valid, req_cmd_out, req_data_out, rsp_resp, rsp_data,
                     rsp_latency, rsp_timeout, spur_cnt);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        run_txn(4'd1, 32'd255, 32'd1, 1, 0, "add_255_1");
        run_txn(4'd1, 32'hFFFF_FFFF, 32'd1, 0, 0, "add_overflow");
    endtask

    task automatic test_sub();
        run_txn(4'd2, 32'd5, 32'd10, 2, 0, "sub_5_10");
        run_txn(4'd2, 32'd10, 32'd5, 0, 0, "sub_10_5");
    endtask

    task automatic test_invalid();
        run_txn(4'd3, 32'd7, 32'd7, 1, 0, "invalid_cmd3");
    endtask

    task automatic test_backpressure();
        run_txn(4'd1, 32'd10, 32'd20, 2, 5, "backpressure");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_txn((i % 2 == 0) ? 4'd5 : 4'd6, $urandom, 32'($urandom_range(0, 31)),
                    i, 0, "b2b_shift");
        end
    endtask

    task automatic test_spurious();
        logic [7:0] s0 = spur_cnt;
        out_resp = 2'd3;
        out_data = 32'hDEAD_BEEF;
        tick();
        out_resp = '0;
        out_data = '0;
        checks++;
        if (spur_cnt !== s0 + 8'd1 || rsp_valid !== 1'b0 || txn_ready !== 1'b1) begin
            errors++;
            $display("FAIL spurious_idle: got spur=%0d vld=%b rdy=%b want spur=%0d vld=0 rdy=1",
                     spur_cnt, rsp_valid, txn_ready, s0 + 8'd1);
        end
    endtask

    task automatic test_reset_mid();
        start_txn(4'd1, 32'd1, 32'd2, "reset_mid");
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (txn_ready !== 1'b1 || rsp_valid !== 1'b0 || req_cmd_out !== 4'd0 ||
            req_data_out !== 32'd0 || rsp_resp !== 2'd0 || rsp_data !== 32'd0 ||
            rsp_latency !== 8'd0 || rsp_timeout !== 1'b0 || spur_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got rdy=%b vld=%b cmd=%0h data=%0h resp=%0d rdata=%0h lat=%0d spur=%0d want rdy=1 rest 0",
                     txn_ready, rsp_valid, req_cmd_out, req_data_out, rsp_resp, rsp_data,
                     rsp_latency, spur_cnt);
        end
        tick();
        reset_n = 1'b1;
        tick();
        out_resp = 2'd1;
        out_data = 32'd3;
        tick();
        out_resp = '0;
        out_data = '0;
        checks++;
        if (spur_cnt !== 8'd1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL late_resp: got spur=%0d vld=%b want spur=1 vld=0", spur_cnt, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || txn_ready !== 1'b1) begin
            errors++;
            $display("FAIL late_resp_idle: got vld=%b rdy=%b want 0 1", rsp_valid, txn_ready);
        end
    endtask

`ifdef CALC1_DRV_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int   early = 0;
        start_txn(4'd0, 32'd4, 32'd4, "timeout");
        e.resp = 2'd0;
        e.data = 32'd0;
        e.lat  = 8'd17;
        e.tmo  = 1'b1;
        sb_q.push_back(e);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (rsp_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_early: got %0d early valid cycles want 0", early);
        end
        tick();
        drain_rsp(0, "timeout");
    endtask
`else
    task automatic test_timeout();
        int seen = 0;
        start_txn(4'd0, 32'd4, 32'd4, "nop_hang");
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || txn_ready !== 1'b0 || rsp_timeout !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL nop_hang: got %0d cycles with result/ready want 0", seen);
        end
        #2;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        txn_valid = 1'b0;
        txn_cmd   = '0;
        txn_op1   = '0;
        txn_op2   = '0;
        out_resp  = '0;
        out_data  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_invalid();
        test_backpressure();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_timeout();
        run_txn(4'd1, 32'd100, 32'd23, 3, 1, "after_recovery");
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/calc1_port_driver.md
Name: calc1_port_driver

Overview:
- Upstream feeder for one calc1 request port; one instance per port (4 total).
- Accepts a whole transaction (cmd, operand1, operand2) over a valid/ready handshake.
- Drives the calc1 two-cycle request protocol, waits for the port response, then returns data, response code and measured latency over a second valid/ready handshake.
- Replaces hand-timed stimulus (fixed delays) with protocol-correct sequencing.

Parameters:
- LAT_W, 8: width of the latency counter (saturating).
- TIMEOUT, 64: cycles to wait for a response before giving up. Only used with CALC1_DRV_TIMEOUT_EN.
- SPUR_W, 8: width of the saturating spurious-response counter.

Ports:
- c_clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- txn_valid  in  1  upstream transaction valid.
- txn_ready  out  1  driver can accept a transaction.
- txn_cmd  in  4  calc1 command (0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH, others passed through unchanged).
- txn_op1  in  32  first operand.
- txn_op2  in  32  second operand.
- req_cmd_out  out  4  to calc1 reqN_cmd_in.
- req_data_out  out  32  to calc1 reqN_data_in.
- out_resp  in  2  from calc1 out_respN.
- out_data  in  32  from calc1 out_dataN.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_resp  out  2  captured response code.
- rsp_data  out  32  captured result data.
- rsp_latency  out  LAT_W  cycles from the command cycle to the response cycle.
- rsp_timeout  out  1  result produced by timeout. Tied 0 without the macro.
- spur_cnt  out  SPUR_W  count of responses seen while not in WAIT.

Behaviour:
- Reset (async, reset_n=0):
  - state IDLE; all outputs 0 except txn_ready=1.
  - All counters cleared.
  - Reset during any state aborts the transaction; nothing is returned.
- All calc-side outputs are registered.
- States: IDLE, CMD, DATA, WAIT, DONE.
- IDLE:
  - txn_ready=1.
  - On txn_valid: latch txn_*, drive req_cmd_out=txn_cmd and req_data_out=txn_op1 next cycle, go to CMD.
- CMD (one cycle on the bus):
  - Next edge: req_cmd_out=0, req_data_out=op2, lat counter=1, go to DATA.
- DATA (one cycle):
  - Next edge: req_data_out=0, lat counter++, go to WAIT.
- WAIT:
  - req_cmd_out=0, req_data_out=0.
  - Each edge, lat counter++ (saturate at all-ones).
  - If out_resp!=0: capture out_resp into rsp_resp, out_data into rsp_data, counter into rsp_latency; set rsp_valid=1; go to DONE.
- DONE:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid=0, go to IDLE (txn_ready=1 the following cycle).
  - No back-to-back overlap: at most one outstanding transaction.
- txn_ready=1 only in IDLE.
- Spurious responses: out_resp!=0 in any state other than WAIT increments spur_cnt (saturating); it is otherwise ignored.
- Response codes are passed through unchanged: 1 success, 2 invalid/overflow, 3 internal error. The driver does not check arithmetic.
- txn_cmd=0 (NOP) is still sequenced. calc1 gives no response, so the driver waits in WAIT indefinitely, or until timeout with the macro.

Optional Feature:
- Macro: CALC1_DRV_TIMEOUT_EN.
- Enabled:
  - WAIT counts cycles.
  - If TIMEOUT cycles pass in WAIT with out_resp==0: rsp_valid=1, rsp_resp=0, rsp_data=0, rsp_timeout=1, rsp_latency=counter value; go to DONE.
  - A response arriving on the same edge as expiry wins (normal capture, rsp_timeout=0).
- Disabled:
  - WAIT is unbounded.
  - rsp_timeout constant 0; no timeout counter logic.

Test Plan:
- ADD 255,1 accepted on cycle 0:
  - cycle 1: req_cmd_out=1, req_data_out=255.
  - cycle 2: cmd 0, data 1.
  - Model returns resp 1, data 256 → rsp_resp=1, rsp_data=256, rsp_latency equals measured cycles.
- SUB 5,10 → rsp_resp=2.
- Invalid cmd 3 with operands 7,7 → bus shows cmd 3 then 0; rsp_resp=2.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_* stay stable and txn_ready=0 throughout.
  - On rsp_ready=1, txn_ready=1 one cycle later.
- Reset mid-operation:
  - Assert reset_n=0 in WAIT → asynchronously all outputs 0, txn_ready=1.
  - A late out_resp=1 after reset increments spur_cnt to 1; rsp_valid stays 0.
- With CALC1_DRV_TIMEOUT_EN, TIMEOUT=16, stub never responds → rsp_valid after 16 WAIT cycles with rsp_resp=0, rsp_timeout=1.
